// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: start control, instruction-ROM port, decoder feedback
// and status. The slave modport is the fetch unit; master is its environment.
// Optional FETCH_STALL_EN adds the stall input.
interface instr_fetch_if;
    logic        start;
    logic [9:0]  start_addr;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic [9:0]  instr_pc;
    logic        branch_en;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic        done;
    logic        halted;
    logic [15:0] cycle_count;
`ifdef FETCH_STALL_EN
    logic        stall;
`endif

    modport slave (
`ifdef FETCH_STALL_EN
        input  stall,
`endif
        input  start, start_addr, imem_data,
        input  branch_en, branch_taken, branch_target, done,
        output imem_addr, instr, instr_valid, instr_pc, halted, cycle_count
    );

    modport master (
`ifdef FETCH_STALL_EN
        output stall,
`endif
        output start, start_addr, imem_data,
        output branch_en, branch_taken, branch_target, done,
        input  imem_addr, instr, instr_valid, instr_pc, halted, cycle_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer for a synchronous instruction ROM.
// Optional build macro: FETCH_STALL_EN (adds a stall input that freezes fetch).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | out of reset, waiting for start
// FILL  | address issued to ROM, no instruction yet (start/branch bubble)
// RUN   | ROM data is a live instruction; next address issued every cycle
// HALT  | program done; halted held until the next start
module instr_fetch (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, HALT} state_t;

    state_t      state, state_nx;
    logic [9:0]  pc, pc_nx;
    logic [15:0] cnt, cnt_nx;
    logic [15:0] cnt_inc;
    logic        stall;
    logic        valid;
    logic [8:0]  instr_live;

`ifdef FETCH_STALL_EN
    // The ROM keeps returning the word at the frozen pc, which is the next
    // instruction, so the one on display is held locally across a stall.
    logic        stall_q;
    logic [8:0]  instr_hold;

    assign stall = bus.stall;

    // Remember the displayed instruction and whether RUN was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q    <= 1'b0;
            instr_hold <= 9'd0;
        end else begin
            stall_q    <= stall && (state == RUN);
            instr_hold <= bus.instr;
        end
    end

    assign instr_live = stall_q ? instr_hold : bus.imem_data;
`else
    assign stall      = 1'b0;
    assign instr_live = bus.imem_data;
`endif

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // State, pc and cycle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= 10'd0;
            cnt   <= 16'd0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; decoder feedback is only looked at in RUN, the one
    // state where instr_valid is high. done outranks a taken branch.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cnt_nx   = cnt;
        case (state)
            IDLE, HALT: begin
                if (bus.start) begin
                    pc_nx    = bus.start_addr;
                    cnt_nx   = 16'd0;
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (!stall) begin
                    pc_nx    = pc + 10'd1;
                    cnt_nx   = cnt_inc;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    cnt_nx = cnt_inc;
                    if (bus.done) begin
                        state_nx = HALT;
                    end else if (bus.branch_en && bus.branch_taken) begin
                        pc_nx    = bus.branch_target;
                        state_nx = FILL;
                    end else begin
                        pc_nx = pc + 10'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode straight from state and pc so reset clears them at once.
    assign valid            = (state == RUN);
    assign bus.imem_addr    = pc;
    assign bus.instr_valid  = valid;
    assign bus.instr        = valid ? instr_live : 9'd0;
    assign bus.instr_pc     = valid ? pc - 10'd1 : 10'd0;
    assign bus.halted       = (state == HALT);
    assign bus.cycle_count  = cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a random phase,
// checked against a transaction-level model of the fetched instruction stream.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst_n;
    instr_fetch_if bus ();

    instr_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [1024];

    // Synchronous instruction ROM: data for last cycle's address.
    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FETCH_STALL_EN
    bit stall_v = 1'b0;
`endif

    // Model: active = program running (bubble or streaming), valid = an
    // instruction is on display at m_pc, m_next = address after a bubble.
    bit          m_active, m_valid, m_halted;
    logic [9:0]  m_pc, m_next;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_active = 0; m_valid = 0; m_halted = 0;
        m_pc = 10'd0; m_next = 10'd0; m_cnt = 16'd0;
    endtask

    task automatic model_edge(input bit st, input logic [9:0] sa, input bit be,
                              input bit bt, input logic [9:0] tg, input bit dn);
        bit frozen;
        frozen = 0;
`ifdef FETCH_STALL_EN
        frozen = stall_v && m_active;
`endif
        if (!m_active) begin
            if (st) begin
                m_active = 1; m_halted = 0; m_valid = 0;
                m_next = sa; m_cnt = 16'd0;
            end
        end else if (!frozen) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (!m_valid) begin
                m_valid = 1; m_pc = m_next;
            end else if (dn) begin
                m_active = 0; m_halted = 1; m_valid = 0;
            end else if (be && bt) begin
                m_valid = 0; m_next = tg;
            end else begin
                m_pc = m_pc + 10'd1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("instr_valid", 16'(bus.instr_valid), 16'(m_valid));
        chk("instr", 16'(bus.instr), m_valid ? 16'(rom[m_pc]) : 16'd0);
        if (m_valid) chk("instr_pc", 16'(bus.instr_pc), 16'(m_pc));
        chk("halted", 16'(bus.halted), 16'(m_halted));
        chk("cycle_count", bus.cycle_count, m_cnt);
    endtask

    task automatic check_reset_outputs();
        chk("rst_imem_addr", 16'(bus.imem_addr), 16'd0);
        chk("rst_instr", 16'(bus.instr), 16'd0);
        chk("rst_valid", 16'(bus.instr_valid), 16'd0);
        chk("rst_instr_pc", 16'(bus.instr_pc), 16'd0);
        chk("rst_halted", 16'(bus.halted), 16'd0);
        chk("rst_cycle_count", bus.cycle_count, 16'd0);
    endtask

    // One clock: drive at the falling edge, advance model at rising edge, check 1 later.
    task automatic cyc(input bit st, input logic [9:0] sa, input bit be,
                       input bit bt, input logic [9:0] tg, input bit dn);
        bus.start = st; bus.start_addr = sa;
        bus.branch_en = be; bus.branch_taken = bt;
        bus.branch_target = tg; bus.done = dn;
`ifdef FETCH_STALL_EN
        bus.stall = stall_v;
`endif
        @(posedge clk);
        model_edge(st, sa, be, bt, tg, dn);
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Sequential fetch; junk decoder flags while nothing is valid, and
    // start pulses while running, must both be ignored.
    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_valid)
                cyc(m_active ? 1'($urandom) : 1'b0, 10'($urandom), 1'b0, 1'b0, 10'($urandom), 1'b0);
            else
                cyc(m_active ? 1'($urandom) : 1'b0, 10'($urandom), 1'($urandom),
                    1'($urandom), 10'($urandom), m_active ? 1'($urandom) : 1'b0);
        end
    endtask

    task automatic run_to(input logic [9:0] pc, input int limit);
        int k;
        k = 0;
        while (!(m_valid && m_pc == pc) && k < limit) begin
            quiet(1);
            k++;
        end
        chk("reach_pc", 16'(bus.instr_pc), 16'(pc));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
        rom[20] = 9'b010000000;
        bus.start = 0; bus.start_addr = 0; bus.branch_en = 0; bus.branch_taken = 0;
        bus.branch_target = 0; bus.done = 0;
`ifdef FETCH_STALL_EN
        bus.stall = 0;
`endif
        model_reset();
        rst_n = 1'b0;
        #3;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(3);

        // Start at 10: one bubble, then 10, 11, 12 back to back.
        cyc(1'b1, 10'd10, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("fill_not_valid", 16'(bus.instr_valid), 16'd0);
        run_to(10'd12, 4);
        // Taken branch at 12 to 40: one bubble, then 40.
        cyc(1'b0, 10'd0, 1'b1, 1'b1, 10'd40, 1'b0);
        chk("bubble_after_branch", 16'(bus.instr_valid), 16'd0);
        run_to(10'd40, 2);
        // Branch back to 12, then a not-taken branch falls through to 13.
        cyc(1'b0, 10'd0, 1'b1, 1'b1, 10'd12, 1'b0);
        run_to(10'd12, 2);
        cyc(1'b0, 10'd0, 1'b1, 1'b0, 10'd777, 1'b0);
        chk("no_bubble_pc13", 16'(bus.instr_pc), 16'd13);

`ifdef FETCH_STALL_EN
        run_to(10'd15, 3);
        stall_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 10'd99, 1'b1, 1'b1, 10'd99, 1'b1);
            chk("stall_pc", 16'(bus.instr_pc), 16'd15);
        end
        stall_v = 1'b0;
`endif

        // done at 20: halted next cycle, count frozen, instr invalid.
        run_to(10'd20, 10);
        cyc(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b1);
        chk("halt_after_done", 16'(bus.halted), 16'd1);
        quiet(4);

        // Restart from HALT at 1023: 1023 wraps to 0; done beats a taken branch.
        cyc(1'b1, 10'd1023, 1'b0, 1'b0, 10'd0, 1'b0);
        run_to(10'd1023, 2);
        cyc(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("wrap_pc0", 16'(bus.instr_pc), 16'd0);
        cyc(1'b0, 10'd0, 1'b1, 1'b1, 10'd300, 1'b1);
        chk("done_priority_halt", 16'(bus.halted), 16'd1);
        quiet(3);

        // Reset mid-run: outputs clear without a clock edge; stay idle after.
        cyc(1'b1, 10'd200, 1'b0, 1'b0, 10'd0, 1'b0);
        quiet(5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(4);
        cyc(1'b1, 10'd500, 1'b0, 1'b0, 10'd0, 1'b0);
        run_to(10'd502, 4);

        // Random phase.
        for (int i = 0; i < 600; i++) begin
`ifdef FETCH_STALL_EN
            stall_v = ($urandom % 6 == 0);
`endif
            cyc($urandom % 8 == 0, 10'($urandom), $urandom % 4 == 0, 1'($urandom),
                10'($urandom), $urandom % 40 == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
